lc4_trace_buffer: RTL and testbench

LC4_TRACE_BUFFER -- requirements
Module: lc4_trace_buffer

---
 rtl/lc4_trace_buffer_pkg.sv | 19 +
 rtl/lc4_trace_fifo.sv | 72 +++++++
 rtl/lc4_trace_buffer.sv | 138 +++++++++++++
 tb/tb_lc4_trace_buffer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc4_trace_buffer_pkg.sv
// Shared LC4 trace-record definitions: field widths, qualifiers and the halt opcode.
package lc4_trace_buffer_pkg;

    localparam int unsigned STALL_W     = 2;
    localparam int unsigned NZP_W       = 3;
    localparam int unsigned HALT_INSN_W = 20;

    localparam logic [STALL_W-1:0]     STALL_NONE = 2'b00;
    localparam logic [HALT_INSN_W-1:0] HALT_INSN  = 20'h88000;

    // Packed record layout: {pc, insn, regfile_we, wsel, wdata, nzp_we, nzp_new_bits}
    function automatic int unsigned rec_width(input int unsigned pc_w,
                                              input int unsigned insn_w,
                                              input int unsigned sel_w,
                                              input int unsigned word_w);
        return pc_w + insn_w + 1 + sel_w + word_w + 1 + NZP_W;
    endfunction

endpackage

// File: rtl/lc4_trace_fifo.sv
// Synchronous FIFO: pointer-addressed storage with registered count/full/empty.
module lc4_trace_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;

    // Storage is not reset; the head is only meaningful while non-empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Pointer/occupancy next-state; pointers wrap naturally at DEPTH (power of two).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;
    assign count = count_q;

endmodule

// File: rtl/lc4_trace_buffer.sv
// LC4 retire-trace buffer: qualifies and masks retire records, queues them,
// and keeps retirement/drop/halt statistics.
module lc4_trace_buffer
    import lc4_trace_buffer_pkg::*;
#(
    parameter int unsigned WORD_SIZE     = 256,
    parameter int unsigned REG_ADDR_BITS = 5,
    parameter int unsigned INSN          = 19,
    parameter int unsigned IADDR         = 10,
    parameter int unsigned DEPTH         = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       gwe,
    input  logic [STALL_W-1:0]         i_test_stall,
    input  logic [IADDR:0]             i_test_pc,
    input  logic [INSN:0]              i_test_insn,
    input  logic                       i_test_regfile_we,
    input  logic [REG_ADDR_BITS-1:0]   i_test_wsel,
    input  logic [WORD_SIZE-1:0]       i_test_wdata,
    input  logic                       i_test_nzp_we,
    input  logic [NZP_W-1:0]           i_test_nzp_new_bits,
    output logic [IADDR:0]             o_rec_pc,
    output logic [INSN:0]              o_rec_insn,
    output logic                       o_rec_regfile_we,
    output logic [REG_ADDR_BITS-1:0]   o_rec_wsel,
    output logic [WORD_SIZE-1:0]       o_rec_wdata,
    output logic                       o_rec_nzp_we,
    output logic [NZP_W-1:0]           o_rec_nzp_new_bits,
    output logic                       o_rec_valid,
    input  logic                       i_rec_ready,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_overflow,
    input  logic                       i_clear_overflow,
    output logic [31:0]                o_retired,
    output logic [15:0]                o_dropped,
    output logic                       o_halt_seen
);

    localparam int unsigned PC_W   = IADDR + 1;
    localparam int unsigned INSN_W = INSN + 1;
    localparam int unsigned REC_W  = rec_width(PC_W, INSN_W, REG_ADDR_BITS, WORD_SIZE);

    logic                     capture_c;
    logic                     push_c;
    logic                     pop_c;
    logic                     drop_c;
    logic                     halt_c;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [REG_ADDR_BITS-1:0] wsel_m;
    logic [WORD_SIZE-1:0]     wdata_m;
    logic [NZP_W-1:0]         nzp_m;
    logic [REC_W-1:0]         rec_in;
    logic [REC_W-1:0]         rec_out;

    logic        overflow_q, overflow_d;
    logic [31:0] retired_q,  retired_d;
    logic [15:0] dropped_q,  dropped_d;
    logic        halt_q,     halt_d;

    // Capture qualification and push/pop/drop arbitration; a pop frees the slot a full capture needs.
    always_comb begin
        capture_c = gwe && (i_test_stall == STALL_NONE);
        pop_c     = !fifo_empty && i_rec_ready;
        push_c    = capture_c && (!fifo_full || pop_c);
        drop_c    = capture_c && fifo_full && !pop_c;
        halt_c    = capture_c && (i_test_insn == INSN_W'(HALT_INSN));
        wsel_m    = i_test_regfile_we ? i_test_wsel  : '0;
        wdata_m   = i_test_regfile_we ? i_test_wdata : '0;
        nzp_m     = i_test_nzp_we     ? i_test_nzp_new_bits : '0;
    end

    assign rec_in = {i_test_pc, i_test_insn, i_test_regfile_we, wsel_m, wdata_m,
                     i_test_nzp_we, nzp_m};

    lc4_trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (push_c),
        .pop   (pop_c),
        .wdata (rec_in),
        .rdata (rec_out),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (o_count)
    );

    assign {o_rec_pc, o_rec_insn, o_rec_regfile_we, o_rec_wsel, o_rec_wdata,
            o_rec_nzp_we, o_rec_nzp_new_bits} = rec_out;
    assign o_rec_valid = !fifo_empty;

    // Statistics next-state; a drop beats a clear so the loss is never hidden.
    always_comb begin
        overflow_d = overflow_q;
        retired_d  = retired_q;
        dropped_d  = dropped_q;
        halt_d     = halt_q;
        if (drop_c) begin
            overflow_d = 1'b1;
        end else if (i_clear_overflow) begin
            overflow_d = 1'b0;
        end
        if (capture_c) begin
            retired_d = retired_q + 32'd1;
        end
        if (drop_c && (dropped_q != 16'hFFFF)) begin
            dropped_d = dropped_q + 16'd1;
        end
        if (halt_c) begin
            halt_d = 1'b1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_q <= 1'b0;
            retired_q  <= '0;
            dropped_q  <= '0;
            halt_q     <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
            retired_q  <= retired_d;
            dropped_q  <= dropped_d;
            halt_q     <= halt_d;
        end
    end

    assign o_overflow  = overflow_q;
    assign o_retired   = retired_q;
    assign o_dropped   = dropped_q;
    assign o_halt_seen = halt_q;

endmodule

// File: tb/tb_lc4_trace_buffer.sv
// Scoreboard bench for lc4_trace_buffer: directed captures push expected records,
// a negedge monitor pops and compares whenever the DUT hands a record over.
module tb_lc4_trace_buffer;

    logic         clk;
    logic         rst;
    logic         gwe;
    logic [1:0]   i_test_stall;
    logic [10:0]  i_test_pc;
    logic [19:0]  i_test_insn;
    logic         i_test_regfile_we;
    logic [4:0]   i_test_wsel;
    logic [255:0] i_test_wdata;
    logic         i_test_nzp_we;
    logic [2:0]   i_test_nzp_new_bits;
    logic [10:0]  o_rec_pc;
    logic [19:0]  o_rec_insn;
    logic         o_rec_regfile_we;
    logic [4:0]   o_rec_wsel;
    logic [255:0] o_rec_wdata;
    logic         o_rec_nzp_we;
    logic [2:0]   o_rec_nzp_new_bits;
    logic         o_rec_valid;
    logic         i_rec_ready;
    logic [3:0]   o_count;
    logic         o_overflow;
    logic         i_clear_overflow;
    logic [31:0]  o_retired;
    logic [15:0]  o_dropped;
    logic         o_halt_seen;

    typedef struct {
        logic [10:0]  pc;
        logic [19:0]  insn;
        logic         rf_we;
        logic [4:0]   wsel;
        logic [255:0] wdata;
        logic         nzp_we;
        logic [2:0]   nzp;
        int           cyc;
        bit           chk_lat;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    lc4_trace_buffer dut (
        .clk                 (clk),
        .rst                 (rst),
        .gwe                 (gwe),
        .i_test_stall        (i_test_stall),
        .i_test_pc           (i_test_pc),
        .i_test_insn         (i_test_insn),
        .i_test_regfile_we   (i_test_regfile_we),
        .i_test_wsel         (i_test_wsel),
        .i_test_wdata        (i_test_wdata),
        .i_test_nzp_we       (i_test_nzp_we),
        .i_test_nzp_new_bits (i_test_nzp_new_bits),
        .o_rec_pc            (o_rec_pc),
        .o_rec_insn          (o_rec_insn),
        .o_rec_regfile_we    (o_rec_regfile_we),
        .o_rec_wsel          (o_rec_wsel),
        .o_rec_wdata         (o_rec_wdata),
        .o_rec_nzp_we        (o_rec_nzp_we),
        .o_rec_nzp_new_bits  (o_rec_nzp_new_bits),
        .o_rec_valid         (o_rec_valid),
        .i_rec_ready         (i_rec_ready),
        .o_count             (o_count),
        .o_overflow          (o_overflow),
        .i_clear_overflow    (i_clear_overflow),
        .o_retired           (o_retired),
        .o_dropped           (o_dropped),
        .o_halt_seen         (o_halt_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [255:0] act,
                                  input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Monitor: every handshake pops the oldest expected record and compares it.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            check("valid_vs_count", 256'(o_rec_valid), 256'(o_count != 4'd0));
            if (o_rec_valid && i_rec_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_record_pc", 256'(o_rec_pc), 256'h0 - 256'd1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rec_pc",     256'(o_rec_pc),           256'(e.pc));
                    check("rec_insn",   256'(o_rec_insn),         256'(e.insn));
                    check("rec_rf_we",  256'(o_rec_regfile_we),   256'(e.rf_we));
                    check("rec_wsel",   256'(o_rec_wsel),         256'(e.wsel));
                    check("rec_wdata",  o_rec_wdata,              e.wdata);
                    check("rec_nzp_we", 256'(o_rec_nzp_we),       256'(e.nzp_we));
                    check("rec_nzp",    256'(o_rec_nzp_new_bits), 256'(e.nzp));
                    if (e.chk_lat) begin
                        check("rec_latency_cycle", 256'(cyc), 256'(e.cyc));
                    end
                end
            end
        end
    end

    // One capture cycle; accepted records are queued with masking applied by the bench.
    task automatic cap(input logic [10:0] pc, input logic [19:0] insn,
                       input logic rf_we, input logic [4:0] wsel,
                       input logic [255:0] wdata, input logic nzp_we,
                       input logic [2:0] nzp, input bit accept, input bit chk_lat);
        exp_t e;
        gwe                 = 1'b1;
        i_test_stall        = 2'b00;
        i_test_pc           = pc;
        i_test_insn         = insn;
        i_test_regfile_we   = rf_we;
        i_test_wsel         = wsel;
        i_test_wdata        = wdata;
        i_test_nzp_we       = nzp_we;
        i_test_nzp_new_bits = nzp;
        if (accept) begin
            e.pc      = pc;
            e.insn    = insn;
            e.rf_we   = rf_we;
            e.wsel    = rf_we ? wsel : 5'd0;
            e.wdata   = rf_we ? wdata : 256'd0;
            e.nzp_we  = nzp_we;
            e.nzp     = nzp_we ? nzp : 3'd0;
            e.cyc     = cyc + 1;
            e.chk_lat = chk_lat;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        gwe = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Drain with a cycle budget; an expired budget shows up as a failed check.
    task automatic drain(input int max_cycles);
        int n = 0;
        i_rec_ready = 1'b1;
        while ((exp_q.size() != 0 || o_count != 4'd0) && n < max_cycles) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_queue_empty", 256'(exp_q.size()), 256'd0);
        check("drain_count",       256'(o_count),      256'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst                 = 1'b0;
        gwe                 = 1'b0;
        i_test_stall        = 2'b00;
        i_test_pc           = '0;
        i_test_insn         = '0;
        i_test_regfile_we   = 1'b0;
        i_test_wsel         = '0;
        i_test_wdata        = '0;
        i_test_nzp_we       = 1'b0;
        i_test_nzp_new_bits = '0;
        i_rec_ready         = 1'b0;
        i_clear_overflow    = 1'b0;

        // Reset state
        do_reset();
        check("reset_valid",    256'(o_rec_valid), 256'd0);
        check("reset_count",    256'(o_count),     256'd0);
        check("reset_overflow", 256'(o_overflow),  256'd0);
        check("reset_retired",  256'(o_retired),   256'd0);
        check("reset_dropped",  256'(o_dropped),   256'd0);
        check("reset_halt",     256'(o_halt_seen), 256'd0);

        // Three in-order captures with a ready consumer, one-cycle latency each
        i_rec_ready = 1'b1;
        cap(11'd0, 20'h01234, 1'b1, 5'd1, 256'h11,   1'b1, 3'b100, 1'b1, 1'b1);
        cap(11'd1, 20'h05678, 1'b1, 5'd2, 256'h22,   1'b1, 3'b010, 1'b1, 1'b1);
        cap(11'd2, 20'h09ABC, 1'b1, 5'd3, 256'h33,   1'b0, 3'b001, 1'b1, 1'b1);
        @(posedge clk); #1;
        check("t1_retired", 256'(o_retired), 256'd3);
        check("t1_count",   256'(o_count),   256'd0);
        check("t1_pending", 256'(exp_q.size()), 256'd0);

        // Overfill with a stalled consumer: 8 kept, 2 dropped
        do_reset();
        i_rec_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cap(11'(i), 20'h10000 + 20'(i), 1'b1, 5'(i), 256'(i * 7), 1'b1, 3'b001,
                (i < 8), 1'b0);
        end
        check("t2_count",    256'(o_count),    256'd8);
        check("t2_overflow", 256'(o_overflow), 256'd1);
        check("t2_dropped",  256'(o_dropped),  256'd2);
        check("t2_retired",  256'(o_retired),  256'd10);
        check("t2_head_pc",  256'(o_rec_pc),   256'd0);
        @(posedge clk); #1;
        check("t2_head_stable", 256'(o_rec_pc), 256'd0);

        // Full buffer with simultaneous capture and pop: accepted at tail
        i_rec_ready = 1'b1;
        cap(11'h100, 20'h2ABCD, 1'b1, 5'd9, 256'hDEAD, 1'b0, 3'b111, 1'b1, 1'b0);
        i_rec_ready = 1'b0;
        check("t3_count",   256'(o_count),   256'd8);
        check("t3_dropped", 256'(o_dropped), 256'd2);
        check("t3_retired", 256'(o_retired), 256'd11);
        check("t3_head_pc", 256'(o_rec_pc),  256'd1);

        // Clear overflow alone, then clear racing a drop of the halt opcode
        i_clear_overflow = 1'b1;
        @(posedge clk); #1;
        i_clear_overflow = 1'b0;
        check("t4_clear_overflow", 256'(o_overflow), 256'd0);
        i_clear_overflow = 1'b1;
        cap(11'h1FF, 20'h88000, 1'b0, 5'd0, 256'd0, 1'b0, 3'b000, 1'b0, 1'b0);
        i_clear_overflow = 1'b0;
        check("t4_overflow_drop_wins", 256'(o_overflow),  256'd1);
        check("t4_dropped",            256'(o_dropped),   256'd3);
        check("t4_halt_seen",          256'(o_halt_seen), 256'd1);
        check("t4_retired",            256'(o_retired),   256'd12);
        check("t4_count",              256'(o_count),     256'd8);
        drain(40);

        // Stalled retirements are ignored; disabled writes are masked to zero
        gwe          = 1'b1;
        i_test_stall = 2'b10;
        i_test_pc    = 11'h55;
        @(posedge clk); #1;
        gwe          = 1'b0;
        i_test_stall = 2'b00;
        check("t5_stall_count",   256'(o_count),   256'd0);
        check("t5_stall_retired", 256'(o_retired), 256'd12);
        cap(11'h77, 20'h3F00F, 1'b0, 5'h1F, {256{1'b1}}, 1'b0, 3'b111, 1'b1, 1'b1);
        cap(11'h78, 20'h40001, 1'b1, 5'd3, 256'hCAFE_F00D, 1'b1, 3'b010, 1'b1, 1'b1);
        drain(20);
        check("t5_retired",   256'(o_retired),   256'd14);
        check("t5_halt_kept", 256'(o_halt_seen), 256'd1);

        // Asynchronous reset mid-drain discards buffered records
        do_reset();
        i_rec_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cap(11'h20 + 11'(i), 20'h50000, 1'b1, 5'd4, 256'(i), 1'b0, 3'b000, 1'b1, 1'b0);
        end
        check("t6_count5", 256'(o_count), 256'd5);
        i_rec_ready = 1'b1;
        @(posedge clk); #1;
        check("t6_count4", 256'(o_count), 256'd4);
        #2;
        rst = 1'b0;
        #1;
        exp_q.delete();
        check("t6_rst_valid",    256'(o_rec_valid), 256'd0);
        check("t6_rst_count",    256'(o_count),     256'd0);
        check("t6_rst_retired",  256'(o_retired),   256'd0);
        check("t6_rst_dropped",  256'(o_dropped),   256'd0);
        check("t6_rst_overflow", 256'(o_overflow),  256'd0);
        check("t6_rst_halt",     256'(o_halt_seen), 256'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        cap(11'h3A, 20'h6789A, 1'b1, 5'd7, 256'h5A5A, 1'b1, 3'b100, 1'b1, 1'b1);
        drain(20);
        check("t6_retired_after", 256'(o_retired), 256'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
